bomb_engine: RTL



---
 rtl/bomb_pkg.sv | 14 +
 rtl/bomb_slot.sv | 123 ++++++++++++
 rtl/bomb_engine.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// Shared types for the bomb engine: slot lifecycle states and tile addressing.
package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        FLAME = 2'd2
    } slot_state_e;

    function automatic int tile_idx(input int x, input int y, input int w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> FUSE -> FLAME -> IDLE, plus its wall-aware flame cross.
// State changes one clk after load/tick/chain; never stalls, load is only honoured in IDLE.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter  int GRID_W      = 16,
    parameter  int GRID_H      = 16,
    parameter  int LEN_W       = 2,
    parameter  int FUSE_TICKS  = 60,
    parameter  int FLAME_TICKS = 18,
    localparam int NT          = GRID_W * GRID_H,
    localparam int CW          = $clog2(NT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [CW-1:0]    i_cor,
    input  logic [LEN_W-1:0] i_len,
    input  logic [NT-1:0]    i_wall_grid,
    input  logic [NT-1:0]    i_flame_grid,
    output logic             o_idle,
    output logic             o_live_nxt,
    output logic [NT-1:0]    o_bomb_nxt,
    output logic [NT-1:0]    o_cross
);

    localparam int CMAX  = (FUSE_TICKS > FLAME_TICKS) ? FUSE_TICKS : FLAME_TICKS;
    localparam int CTW   = $clog2(CMAX + 1);
    localparam int REACH = 1 << LEN_W;

    slot_state_e      r_state, w_state_nxt;
    logic [CTW-1:0]   r_ctr, w_ctr_nxt;
    logic [CW-1:0]    r_cor, w_cor_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;

    logic [NT-1:0]    w_cross;
    logic             w_go;
    int               w_x, w_y, w_nx, w_ny;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ctr   <= '0;
            r_cor   <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ctr   <= w_ctr_nxt;
            r_cor   <= w_cor_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctr_nxt   = r_ctr;
        w_cor_nxt   = r_cor;
        w_len_nxt   = r_len;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_state_nxt = FUSE;
                    w_ctr_nxt   = CTW'(FUSE_TICKS);
                    w_cor_nxt   = i_cor;
                    w_len_nxt   = i_len;
                end
            end
            FUSE: begin
                // A neighbouring flame detonates the bomb immediately, ignoring tick.
                if (i_flame_grid[r_cor] || (i_tick && r_ctr == CTW'(1))) begin
                    w_state_nxt = FLAME;
                    w_ctr_nxt   = CTW'(FLAME_TICKS);
                end else if (i_tick) begin
                    w_ctr_nxt = r_ctr - CTW'(1);
                end
            end
            FLAME: begin
                if (i_tick) begin
                    if (r_ctr == CTW'(1)) w_state_nxt = IDLE;
                    else                  w_ctr_nxt   = r_ctr - CTW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Arms: d=0 right, 1 left, 2 down, 3 up; each stops at the edge or a wall.
    always_comb begin
        w_cross        = '0;
        w_go           = 1'b0;
        w_nx           = 0;
        w_ny           = 0;
        w_x            = int'(r_cor) % GRID_W;
        w_y            = int'(r_cor) / GRID_W;
        w_cross[r_cor] = 1'b1;
        for (int d = 0; d < 4; d++) begin
            w_go = 1'b1;
            for (int k = 1; k <= REACH; k++) begin
                w_nx = w_x + ((d == 0) ? k : (d == 1) ? -k : 0);
                w_ny = w_y + ((d == 2) ? k : (d == 3) ? -k : 0);
                if (w_go && (k <= int'(r_len) + 1)) begin
                    if (w_nx < 0 || w_nx >= GRID_W || w_ny < 0 || w_ny >= GRID_H)
                        w_go = 1'b0;
                    else if (i_wall_grid[CW'(tile_idx(w_nx, w_ny, GRID_W))])
                        w_go = 1'b0;
                    else
                        w_cross[CW'(tile_idx(w_nx, w_ny, GRID_W))] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_bomb_nxt = '0;
        if (w_state_nxt == FUSE) o_bomb_nxt[w_cor_nxt] = 1'b1;
    end

    assign o_idle     = (r_state == IDLE);
    assign o_live_nxt = (w_state_nxt != IDLE);
    assign o_cross    = (r_state == FLAME) ? w_cross : '0;

endmodule

// File: rtl/bomb_engine.sv
// Bomb manager: arbitrates puts into per-player slot pools and drives bomb/flame grids.
// Ack, bomb_grid and bomb_num one clk after a put; flame_grid one clk after FLAME; rejected puts dropped.
module bomb_engine
    import bomb_pkg::*;
#(
    parameter  int GRID_W      = 16,
    parameter  int GRID_H      = 16,
    parameter  int N_PLAYERS   = 2,
    parameter  int MAX_BOMBS   = 4,
    parameter  int LEN_W       = 2,
    parameter  int FUSE_TICKS  = 60,
    parameter  int FLAME_TICKS = 18,
    localparam int NT          = GRID_W * GRID_H,
    localparam int CW          = $clog2(NT),
    localparam int NS          = N_PLAYERS * MAX_BOMBS,
    localparam int NW          = $clog2(MAX_BOMBS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [N_PLAYERS-1:0]      put,
    input  logic [N_PLAYERS*CW-1:0]   cor,
    input  logic [N_PLAYERS*LEN_W-1:0] bomb_len,
    input  logic [NT-1:0]             wall_grid,
    output logic [N_PLAYERS-1:0]      put_ack,
    output logic [NT-1:0]             bomb_grid,
    output logic [NT-1:0]             flame_grid,
    output logic [N_PLAYERS*NW-1:0]   bomb_num
);

    logic [N_PLAYERS-1:0]    r_put_ack;
    logic [NT-1:0]           r_bomb_grid, r_flame_grid;
    logic [N_PLAYERS*NW-1:0] r_bomb_num;

    logic [CW-1:0]           w_cor [N_PLAYERS];
    logic [LEN_W-1:0]        w_len [N_PLAYERS];
    logic [NS-1:0]           w_slot_idle, w_slot_live_nxt, w_load;
    logic [NT-1:0]           w_bomb_nxt [NS];
    logic [NT-1:0]           w_cross [NS];
    logic [N_PLAYERS-1:0]    w_free, w_acc;
    logic                    w_taken;
    logic [NT-1:0]           w_bomb_or, w_flame_or;
    logic [N_PLAYERS*NW-1:0] w_num;
    int                      w_cnt;

    for (genvar gp = 0; gp < N_PLAYERS; gp++) begin : g_unpack
        assign w_cor[gp] = cor[gp*CW +: CW];
        assign w_len[gp] = bomb_len[gp*LEN_W +: LEN_W];
    end

    for (genvar gs = 0; gs < NS; gs++) begin : g_slot
        localparam int P = gs / MAX_BOMBS;
        bomb_slot #(
            .GRID_W      (GRID_W),
            .GRID_H      (GRID_H),
            .LEN_W       (LEN_W),
            .FUSE_TICKS  (FUSE_TICKS),
            .FLAME_TICKS (FLAME_TICKS)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .i_tick       (tick),
            .i_load       (w_load[gs]),
            .i_cor        (w_cor[P]),
            .i_len        (w_len[P]),
            .i_wall_grid  (wall_grid),
            .i_flame_grid (r_flame_grid),
            .o_idle       (w_slot_idle[gs]),
            .o_live_nxt   (w_slot_live_nxt[gs]),
            .o_bomb_nxt   (w_bomb_nxt[gs]),
            .o_cross      (w_cross[gs])
        );
    end

    // Lower-indexed players win a shared tile; the winner loads its lowest idle slot.
    always_comb begin
        w_free  = '0;
        w_acc   = '0;
        w_load  = '0;
        w_taken = 1'b0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            for (int s = 0; s < MAX_BOMBS; s++) begin
                if (w_slot_idle[p*MAX_BOMBS + s]) w_free[p] = 1'b1;
            end
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            w_acc[p] = put[p] && (int'(w_cor[p]) < NT) && !wall_grid[w_cor[p]]
                    && !r_bomb_grid[w_cor[p]] && !r_flame_grid[w_cor[p]] && w_free[p];
            for (int q = 0; q < p; q++) begin
                if (w_acc[q] && (w_cor[q] == w_cor[p])) w_acc[p] = 1'b0;
            end
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            w_taken = 1'b0;
            for (int s = 0; s < MAX_BOMBS; s++) begin
                if (!w_taken && w_slot_idle[p*MAX_BOMBS + s]) begin
                    w_taken                  = 1'b1;
                    w_load[p*MAX_BOMBS + s]  = w_acc[p];
                end
            end
        end
    end

    always_comb begin
        w_bomb_or  = '0;
        w_flame_or = '0;
        w_num      = '0;
        w_cnt      = 0;
        for (int s = 0; s < NS; s++) begin
            w_bomb_or  = w_bomb_or  | w_bomb_nxt[s];
            w_flame_or = w_flame_or | w_cross[s];
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            w_cnt = 0;
            for (int s = 0; s < MAX_BOMBS; s++) begin
                w_cnt = w_cnt + int'(w_slot_live_nxt[p*MAX_BOMBS + s]);
            end
            w_num[p*NW +: NW] = NW'(w_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_put_ack    <= '0;
            r_bomb_grid  <= '0;
            r_flame_grid <= '0;
            r_bomb_num   <= '0;
        end else begin
            r_put_ack    <= w_acc;
            r_bomb_grid  <= w_bomb_or;
            r_flame_grid <= w_flame_or;
            r_bomb_num   <= w_num;
        end
    end

    assign put_ack    = r_put_ack;
    assign bomb_grid  = r_bomb_grid;
    assign flame_grid = r_flame_grid;
    assign bomb_num   = r_bomb_num;

endmodule
